// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the MEM-stage load/store unit
//
// Contents:
//   state_e     - LSU bus FSM states
//   F3_*        - funct3 encodings for access width / signedness
//   mem_exc_e   - exception cause reported on MemExcW
//   f3_supported- true for the funct3 values the LSU can execute
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'b00,
        EXC_MISALIGN = 2'b01,
        EXC_BUSERR   = 2'b10,
        EXC_TIMEOUT  = 2'b11
    } mem_exc_e;

    function automatic logic f3_supported(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - alignment check, store lane placement and load extraction
//
// Ports:
//   funct3     in  3  : width/signedness of the access being issued
//   addr_lo    in  2  : low address bits of the access being issued
//   store_data in  32 : rs2 value for stores
//   access_ok  out 1  : funct3 supported and address naturally aligned
//   be         out 4  : byte enables for a store of this width/offset
//   wdata      out 32 : store data replicated across all lanes
//   ld_funct3  in  3  : funct3 of the completed load
//   ld_offset  in  2  : byte offset of the completed load
//   rdata      in  32 : captured read word
//   load_data  out 32 : extracted and extended load result
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    output logic        access_ok,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic        misaligned;
    logic [31:0] shifted;

    always_comb begin
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        access_ok  = f3_supported(funct3) && !misaligned;
    end

    // Replicating the data across lanes lets the slave pick whichever lane
    // the byte enables select, without a data shifter on the request path.
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        shifted = rdata >> {ld_offset, 3'b000};
        case (ld_funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV32I MEM stage with valid/ready load/store unit and MEM/WB register
//
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   ValidM .. funct3M                  : MEM-stage instruction fields
//   StallM                             : hold IF/ID/EX/MEM while an access is outstanding
//   mem_req_valid/ready/we/addr/be/wdata : request channel (word-aligned address)
//   mem_rsp_valid/rdata/err            : response channel
//   ValidW .. ALUResultW               : MEM/WB pipeline register
//   MemExcW                            : 00 none, 01 misaligned/unsupported, 10 bus error, 11 timeout
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ValidM,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic                  MemWriteM,
    input  logic                  MemReadM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [4:0]            RdM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,
    input  logic [2:0]            funct3M,
    output logic                  StallM,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [3:0]            mem_req_be,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
    input  logic                  mem_rsp_err,
    output logic                  ValidW,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic [4:0]            RdW,
    output logic [DATA_WIDTH-1:0] PCPlus4W,
    output logic [DATA_WIDTH-1:0] ALUResultW,
    output logic [1:0]            MemExcW
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("mem_stage_lsu: DATA_WIDTH must be 32");
    end
    if (ADDR_WIDTH > 32 || ADDR_WIDTH < 3) begin : g_bad_addr_width
        $error("mem_stage_lsu: ADDR_WIDTH must be in 3..32");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("mem_stage_lsu: TIMEOUT_CYCLES must be at least 2");
    end

    state_e          state;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]      off_q;
    logic [2:0]      f3_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    mem_exc_e        exc_q;

    logic            access_ok;
    logic [3:0]      lane_be;
    logic [31:0]     lane_wdata;
    logic [31:0]     load_data;

    logic            mem_op;
    logic            start;
    logic            reject;
    mem_exc_e        done_exc;
    logic [31:0]     done_rdata;

    lsu_lane_align u_lane (
        .funct3     (funct3M),
        .addr_lo    (ALUResultM[1:0]),
        .store_data (WriteDataM),
        .access_ok  (access_ok),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .ld_funct3  (f3_q),
        .ld_offset  (off_q),
        .rdata      (rdata_q),
        .load_data  (load_data)
    );

    always_comb begin
        mem_op = ValidM && (MemReadM || MemWriteM);
        start  = (state == IDLE) && mem_op && access_ok;
        reject = (state == IDLE) && mem_op && !access_ok;
        // Gated by rst_n so the hazard unit sees no stall while reset is held,
        // even though IDLE would otherwise flag a pending memory op.
        StallM = rst_n && (start || (state == REQ) || (state == WAIT));
        done_exc   = err_q ? EXC_BUSERR : exc_q;
        done_rdata = (mem_req_we || (done_exc != EXC_NONE)) ? 32'h0 : load_data;
    end

    // Bus FSM: request fields are latched on entry to REQ and stay stable
    // until the slave accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_be    <= 4'h0;
            mem_req_wdata <= '0;
            off_q         <= 2'b00;
            f3_q          <= 3'b000;
            rdata_q       <= 32'h0;
            err_q         <= 1'b0;
            exc_q         <= EXC_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= REQ;
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= MemWriteM;
                        mem_req_addr  <= {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
                        mem_req_be    <= MemWriteM ? lane_be : 4'b1111;
                        mem_req_wdata <= MemWriteM ? lane_wdata : '0;
                        off_q         <= ALUResultM[1:0];
                        f3_q          <= funct3M;
                        rdata_q       <= 32'h0;
                        err_q         <= 1'b0;
                        exc_q         <= EXC_NONE;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state         <= WAIT;
                        mem_req_valid <= 1'b0;
                        wait_cnt      <= '0;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        rdata_q <= mem_rsp_rdata;
                        err_q   <= mem_rsp_err;
                        state   <= DONE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        exc_q <= EXC_TIMEOUT;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // MEM/WB register. Stall cycles insert a bubble; DONE commits the
    // completed access with its extracted data and exception cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ValidW     <= 1'b0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ReadDataW  <= '0;
            RdW        <= 5'd0;
            PCPlus4W   <= '0;
            ALUResultW <= '0;
            MemExcW    <= EXC_NONE;
        end else if (StallM) begin
            ValidW    <= 1'b0;
            RegWriteW <= 1'b0;
            MemExcW   <= EXC_NONE;
        end else begin
            ValidW     <= ValidM;
            ResultSrcW <= ResultSrcM;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            ALUResultW <= ALUResultM;
            if (state == DONE) begin
                ReadDataW <= done_rdata;
                MemExcW   <= done_exc;
                RegWriteW <= RegWriteM && (done_exc == EXC_NONE);
            end else if (reject) begin
                ReadDataW <= '0;
                MemExcW   <= EXC_MISALIGN;
                RegWriteW <= 1'b0;
            end else begin
                ReadDataW <= '0;
                MemExcW   <= EXC_NONE;
                RegWriteW <= RegWriteM;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ValidM, RegWriteM, MemWriteM, MemReadM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic [2:0]  funct3M;
    logic        StallM;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_be;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid, mem_rsp_err;
    logic [31:0] mem_rsp_rdata;
    logic        ValidW, RegWriteW;
    logic [1:0]  ResultSrcW, MemExcW;
    logic [31:0] ReadDataW, PCPlus4W, ALUResultW;
    logic [4:0]  RdW;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ValidM        (ValidM),
        .RegWriteM     (RegWriteM),
        .ResultSrcM    (ResultSrcM),
        .MemWriteM     (MemWriteM),
        .MemReadM      (MemReadM),
        .ALUResultM    (ALUResultM),
        .WriteDataM    (WriteDataM),
        .RdM           (RdM),
        .PCPlus4M      (PCPlus4M),
        .funct3M       (funct3M),
        .StallM        (StallM),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_be    (mem_req_be),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .mem_rsp_err   (mem_rsp_err),
        .ValidW        (ValidW),
        .RegWriteW     (RegWriteW),
        .ResultSrcW    (ResultSrcW),
        .ReadDataW     (ReadDataW),
        .RdW           (RdW),
        .PCPlus4W      (PCPlus4W),
        .ALUResultW    (ALUResultW),
        .MemExcW       (MemExcW)
    );

    typedef struct {
        string       name;
        logic        vm, rw, mw, mr;
        logic [2:0]  f3;
        logic [31:0] addr, wd;
        logic [4:0]  rd;
        int          rwait, swait;
        logic [31:0] rdata;
        logic        err;
        logic        bus;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        int          e_stall;
        logic        e_validw, e_regw;
        logic [31:0] e_read;
        logic [1:0]  e_exc;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_m(input logic vm, input logic rw, input logic mw, input logic mr,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd);
        ValidM     = vm;
        RegWriteM  = rw;
        MemWriteM  = mw;
        MemReadM   = mr;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
        RdM        = rd;
        ResultSrcM = mr ? 2'b01 : 2'b00;
        PCPlus4M   = addr + 32'd4;
    endtask

    task automatic run_vec(input vec_t v);
        int stall_cnt;
        drive_m(v.vm, v.rw, v.mw, v.mr, v.f3, v.addr, v.wd, v.rd);
        #1;
        chk({v.name, ".stall_idle"}, {31'h0, StallM}, {31'h0, v.bus});
        stall_cnt = StallM ? 1 : 0;
        step();
        if (v.bus) begin
            chk({v.name, ".req_valid"}, {31'h0, mem_req_valid}, 32'h1);
            chk({v.name, ".req_addr"}, mem_req_addr, v.e_addr);
            chk({v.name, ".req_be"}, {28'h0, mem_req_be}, {28'h0, v.e_be});
            chk({v.name, ".req_we"}, {31'h0, mem_req_we}, {31'h0, v.mw});
            if (v.mw) chk({v.name, ".req_wdata"}, mem_req_wdata, v.e_wdata);
            for (int k = 0; k <= v.rwait; k++) begin
                if (StallM) stall_cnt++;
                mem_req_ready = (k == v.rwait);
                step();
            end
            mem_req_ready = 1'b0;
            for (int j = 0; j <= v.swait; j++) begin
                if (StallM) stall_cnt++;
                if (j == v.swait) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = v.rdata;
                    mem_rsp_err   = v.err;
                end
                step();
            end
            mem_rsp_valid = 1'b0;
            mem_rsp_err   = 1'b0;
            chk({v.name, ".stall_done"}, {31'h0, StallM}, 32'h0);
            chk({v.name, ".stall_cycles"}, stall_cnt, v.e_stall);
            chk({v.name, ".bubble"}, {31'h0, ValidW}, 32'h0);
            chk({v.name, ".req_dropped"}, {31'h0, mem_req_valid}, 32'h0);
            step();
        end
        chk({v.name, ".validw"}, {31'h0, ValidW}, {31'h0, v.e_validw});
        chk({v.name, ".regwritew"}, {31'h0, RegWriteW}, {31'h0, v.e_regw});
        chk({v.name, ".rdw"}, {27'h0, RdW}, {27'h0, v.rd});
        chk({v.name, ".aluw"}, ALUResultW, v.addr);
        chk({v.name, ".excw"}, {30'h0, MemExcW}, {30'h0, v.e_exc});
        if (v.e_exc == 2'b00) chk({v.name, ".readw"}, ReadDataW, v.e_read);
    endtask

    initial begin
        int wcnt;

        // name vm rw mw mr f3 addr wd rd rwait swait rdata err bus e_addr e_be e_wdata e_stall e_validw e_regw e_read e_exc
        vecs[0]  = '{"alu",     1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5,  0, 0, 32'h0,         1'b0,
                     1'b0, 32'h0,     4'h0,    32'h0,         0, 1'b1, 1'b1, 32'h0,         2'b00};
        vecs[1]  = '{"sb",      1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'hAB, 5'd0, 1, 1, 32'h0,         1'b0,
                     1'b1, 32'h100,   4'b1000, 32'hABAB_ABAB, 5, 1'b1, 1'b0, 32'h0,         2'b00};
        vecs[2]  = '{"lb",      1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0202, 32'h0, 5'd7,  0, 0, 32'h0080_0000, 1'b0,
                     1'b1, 32'h200,   4'b1111, 32'h0,         3, 1'b1, 1'b1, 32'hFFFF_FF80, 2'b00};
        vecs[3]  = '{"lbu",     1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 32'h0000_0202, 32'h0, 5'd8,  0, 0, 32'h0080_0000, 1'b0,
                     1'b1, 32'h200,   4'b1111, 32'h0,         3, 1'b1, 1'b1, 32'h0000_0080, 2'b00};
        vecs[4]  = '{"lh",      1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0, 5'd9,  0, 0, 32'h8001_0000, 1'b0,
                     1'b1, 32'h200,   4'b1111, 32'h0,         3, 1'b1, 1'b1, 32'hFFFF_8001, 2'b00};
        vecs[5]  = '{"lw_mis",  1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0006, 32'h0, 5'd10, 0, 0, 32'h0,         1'b0,
                     1'b0, 32'h0,     4'h0,    32'h0,         0, 1'b1, 1'b0, 32'h0,         2'b01};
        vecs[6]  = '{"lw_err",  1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h0, 5'd11, 0, 0, 32'hDEAD_BEEF, 1'b1,
                     1'b1, 32'h300,   4'b1111, 32'h0,         3, 1'b1, 1'b0, 32'h0,         2'b10};
        vecs[7]  = '{"sh",      1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h1234_CDEF, 5'd0, 0, 0, 32'h0, 1'b0,
                     1'b1, 32'h100,   4'b1100, 32'hCDEF_CDEF, 3, 1'b1, 1'b0, 32'h0,         2'b00};
        vecs[8]  = '{"sw",      1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h1122_3344, 5'd0, 0, 0, 32'h0, 1'b0,
                     1'b1, 32'h40,    4'b1111, 32'h1122_3344, 3, 1'b1, 1'b0, 32'h0,         2'b00};
        vecs[9]  = '{"lhu",     1'b1, 1'b1, 1'b0, 1'b1, 3'b101, 32'h0000_0200, 32'h0, 5'd12, 2, 3, 32'hBEEF_F00D, 1'b0,
                     1'b1, 32'h200,   4'b1111, 32'h0,         8, 1'b1, 1'b1, 32'h0000_F00D, 2'b00};
        vecs[10] = '{"f3_011",  1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 32'h0000_0000, 32'h0, 5'd13, 0, 0, 32'h0,         1'b0,
                     1'b0, 32'h0,     4'h0,    32'h0,         0, 1'b1, 1'b0, 32'h0,         2'b01};
        vecs[11] = '{"novalid", 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0044, 32'h0, 5'd14, 0, 0, 32'h0,         1'b0,
                     1'b0, 32'h0,     4'h0,    32'h0,         0, 1'b0, 1'b0, 32'h0,         2'b00};
        vecs[12] = '{"lh_mis",  1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0201, 32'h0, 5'd15, 0, 0, 32'h0,         1'b0,
                     1'b0, 32'h0,     4'h0,    32'h0,         0, 1'b1, 1'b0, 32'h0,         2'b01};

        rst_n         = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        mem_rsp_err   = 1'b0;
        drive_m(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        #2;
        chk("rst.stall", {31'h0, StallM}, 32'h0);
        chk("rst.req_valid", {31'h0, mem_req_valid}, 32'h0);
        chk("rst.validw", {31'h0, ValidW}, 32'h0);
        chk("rst.aluw", ALUResultW, 32'h0);
        chk("rst.excw", {30'h0, MemExcW}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Timeout: accepted load with no response; a late response is ignored.
        drive_m(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h500, 32'h0, 5'd3);
        step();
        chk("to.req_valid", {31'h0, mem_req_valid}, 32'h1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        wcnt = 0;
        while (StallM && wcnt < 20) begin
            wcnt++;
            step();
        end
        chk("to.wait_cycles", wcnt, 8);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h1234_5678;
        step();
        chk("to.excw", {30'h0, MemExcW}, 32'h3);
        chk("to.regwritew", {31'h0, RegWriteW}, 32'h0);
        chk("to.validw", {31'h0, ValidW}, 32'h1);
        drive_m(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        step();
        mem_rsp_valid = 1'b0;
        chk("to.idle_stall", {31'h0, StallM}, 32'h0);
        chk("to.idle_validw", {31'h0, ValidW}, 32'h0);
        chk("to.idle_excw", {30'h0, MemExcW}, 32'h0);

        // Asynchronous reset while waiting for a response.
        drive_m(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h600, 32'h0, 5'd4);
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        chk("rw.in_wait_stall", {31'h0, StallM}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw.req_valid", {31'h0, mem_req_valid}, 32'h0);
        chk("rw.stall", {31'h0, StallM}, 32'h0);
        chk("rw.validw", {31'h0, ValidW}, 32'h0);
        chk("rw.rdw", {27'h0, RdW}, 32'h0);
        chk("rw.pcw", PCPlus4W, 32'h0);
        chk("rw.req_be", {28'h0, mem_req_be}, 32'h0);
        drive_m(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rw.stray_validw", {31'h0, ValidW}, 32'h0);
        chk("rw.stray_readw", ReadDataW, 32'h0);
        chk("rw.stray_req", {31'h0, mem_req_valid}, 32'h0);
        mem_rsp_valid = 1'b0;
        drive_m(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd6);
        #1;
        chk("rw.alu_stall", {31'h0, StallM}, 32'h0);
        step();
        chk("rw.alu_aluw", ALUResultW, 32'h55);
        chk("rw.alu_validw", {31'h0, ValidW}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
